// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch queue and branch redirect
// Owns the PC, issues 1-cycle-latency imem reads and queues {instr, pc} for the decoder.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4,
  parameter int              PTR_W    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_r_enable,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            inflight_o
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  q_instr [DEPTH];
  logic [XLEN-1:0]  q_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic [XLEN-1:0]  fetch_pc, resp_pc;
  logic [XLEN-1:0]  target_aligned;
  logic [CNT_W:0]   occupancy;
  logic             pop, push, issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign target_aligned = branch_target & ~XLEN'(3);
  assign out_valid      = (count != '0);
  assign pop            = out_valid & out_ready & ~branch_en;
  // Slots already promised: queued entries plus the response still on its way.
  assign occupancy      = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
  assign issue          = rst & (branch_en | (occupancy < DEPTH_C));
  // A response arriving during a redirect belongs to the abandoned path.
  assign push           = inflight & ~branch_en;

  assign imem_r_enable  = issue;
  assign imem_addr      = branch_en ? target_aligned : fetch_pc;
  assign out_instr      = out_valid ? q_instr[rd_ptr] : '0;
  assign out_pc         = out_valid ? q_pc[rd_ptr]    : '0;
  assign inflight_o     = inflight;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        resp_pc  <= imem_addr;
        fetch_pc <= imem_addr + XLEN'(4);
      end
      if (branch_en) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_r_enable;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        inflight_o;

  int checks   = 0;
  int failures = 0;
  int issue_cnt = 0;
  int issue_base;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_r_enable(imem_r_enable), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .branch_en(branch_en), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .inflight_o(inflight_o)
  );

  always #5 clk = ~clk;

  // Memory returns the word index of the address one cycle after the strobe.
  always @(posedge clk) begin
    if (imem_r_enable) begin
      imem_rdata <= imem_addr >> 2;
      issue_cnt  <= issue_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b1; branch_en = 1'b0; branch_target = '0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ren", 32'(imem_r_enable), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);

    // streaming from reset
    rst = 1'b1; #1;
    chk("s_ren0", 32'(imem_r_enable), 32'd1);
    chk("s_addr0", imem_addr, 32'h0);
    step();
    chk("s_addr1", imem_addr, 32'h4);
    chk("s_valid1", 32'(out_valid), 32'd0);
    chk("s_inflight1", 32'(inflight_o), 32'd1);
    step();
    chk("s_valid2", 32'(out_valid), 32'd1);
    chk("s_pc2", out_pc, 32'h0);
    chk("s_instr2", out_instr, 32'h0);
    chk("s_addr2", imem_addr, 32'h8);
    step();
    chk("s_pc3", out_pc, 32'h4);
    chk("s_instr3", out_instr, 32'h1);
    step();
    chk("s_pc4", out_pc, 32'h8);
    chk("s_instr4", out_instr, 32'h2);

    // backpressure fills the queue
    rst = 1'b0; step();
    out_ready = 1'b0; rst = 1'b1; #1;
    issue_base = issue_cnt;
    step(); step(); step(); step();
    chk("bp_ren4", 32'(imem_r_enable), 32'd0);
    chk("bp_addr4", imem_addr, 32'h10);
    chk("bp_valid4", 32'(out_valid), 32'd1);
    chk("bp_pc4", out_pc, 32'h0);
    step();
    chk("bp_ren5", 32'(imem_r_enable), 32'd0);
    step();
    chk("bp_issues", 32'(issue_cnt - issue_base), 32'd4);
    chk("bp_pc6", out_pc, 32'h0);
    out_ready = 1'b1; #1;
    chk("bp_ren_pop", 32'(imem_r_enable), 32'd1);
    chk("bp_addr_pop", imem_addr, 32'h10);
    step(); chk("dr_pc0", out_pc, 32'h4);
    step(); chk("dr_pc1", out_pc, 32'h8);
    step(); chk("dr_pc2", out_pc, 32'hC);
    step(); chk("dr_pc3", out_pc, 32'h10);
    chk("dr_instr3", out_instr, 32'h4);

    // redirect with 3 queued entries and a read in flight
    rst = 1'b0; out_ready = 1'b0; step();
    rst = 1'b1; #1;
    step(); step(); step(); step();
    out_ready = 1'b1; branch_en = 1'b1; branch_target = 32'h103; #1;
    chk("br_ren", 32'(imem_r_enable), 32'd1);
    chk("br_addr", imem_addr, 32'h100);
    step();
    branch_en = 1'b0; #1;
    chk("br_valid1", 32'(out_valid), 32'd0);
    chk("br_addr1", imem_addr, 32'h104);
    step();
    chk("br_valid2", 32'(out_valid), 32'd1);
    chk("br_pc2", out_pc, 32'h100);
    chk("br_instr2", out_instr, 32'h40);
    step();
    chk("br_pc3", out_pc, 32'h104);

    // back-to-back redirects
    branch_en = 1'b1; branch_target = 32'h40; #1;
    chk("bb_addr0", imem_addr, 32'h40);
    step();
    branch_target = 32'h80; #1;
    chk("bb_addr1", imem_addr, 32'h80);
    chk("bb_valid1", 32'(out_valid), 32'd0);
    step();
    branch_en = 1'b0; #1;
    chk("bb_valid2", 32'(out_valid), 32'd0);
    chk("bb_addr2", imem_addr, 32'h84);
    step();
    chk("bb_valid3", 32'(out_valid), 32'd1);
    chk("bb_pc3", out_pc, 32'h80);
    chk("bb_instr3", out_instr, 32'h20);
    step();
    chk("bb_pc4", out_pc, 32'h84);

    // PC wraparound
    branch_en = 1'b1; branch_target = 32'hFFFF_FFF9; #1;
    chk("wr_addr0", imem_addr, 32'hFFFF_FFF8);
    step();
    branch_en = 1'b0; #1;
    chk("wr_addr1", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_pc0", out_pc, 32'hFFFF_FFF8);
    chk("wr_instr0", out_instr, 32'h3FFF_FFFE);
    chk("wr_addr2", imem_addr, 32'h0);
    step();
    chk("wr_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wr_pc2", out_pc, 32'h0);
    chk("wr_instr2", out_instr, 32'h0);

    // reset while busy
    rst = 1'b0; out_ready = 1'b0; step();
    rst = 1'b1; #1;
    step(); step(); step(); step();
    rst = 1'b0; #1;
    chk("mr_ren_comb", 32'(imem_r_enable), 32'd0);
    step();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_pc", out_pc, 32'h0);
    chk("mr_instr", out_instr, 32'h0);
    chk("mr_inflight", 32'(inflight_o), 32'd0);
    chk("mr_addr", imem_addr, 32'h0);
    out_ready = 1'b1; rst = 1'b1; #1;
    chk("mr_ren0", 32'(imem_r_enable), 32'd1);
    step();
    chk("mr_valid1", 32'(out_valid), 32'd0);
    step();
    chk("mr_valid2", 32'(out_valid), 32'd1);
    chk("mr_pc2", out_pc, 32'h0);
    chk("mr_instr2", out_instr, 32'h0);
    step();
    chk("mr_pc3", out_pc, 32'h4);
    chk("mr_instr3", out_instr, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
